// File: rtl/address_hold_buffer.sv
// In-order hold buffer for outstanding DDR request addresses.
// First-word fall-through head plus a combinational write-hazard lookup.
module address_hold_buffer #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic                     push_is_write,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [ADDR_W-1:0]        pop_addr,
  output logic [TAG_W-1:0]         pop_tag,
  output logic                     pop_is_write,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0]  wr_q;
  logic [DEPTH-1:0]  vld_q;

  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic do_push;
  logic do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign push_ready = !full;
  assign pop_valid  = !empty;

  // Flush wins over both handshakes in the same cycle.
  assign do_push = push_valid && push_ready && !flush;
  assign do_pop  = pop_valid && pop_ready && !flush;

  always_comb begin
    pop_addr     = '0;
    pop_tag      = '0;
    pop_is_write = 1'b0;
    if (!empty) begin
      pop_addr     = addr_q[rptr_q];
      pop_tag      = tag_q[rptr_q];
      pop_is_write = wr_q[rptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && wr_q[i] && (addr_q[i] == lookup_addr)) begin
        lookup_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      count_q <= count_d;
      if (do_pop) begin
        rptr_q         <= rptr_q + PTR_W'(1);
        vld_q[rptr_q]  <= 1'b0;
      end
      if (do_push) begin
        wptr_q         <= wptr_q + PTR_W'(1);
        vld_q[wptr_q]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_q <= '0;
    end else if (do_push) begin
      addr_q[wptr_q] <= push_addr;
      tag_q[wptr_q]  <= push_tag;
      wr_q[wptr_q]   <= push_is_write;
    end
  end

endmodule

// File: tb/tb_address_hold_buffer.sv
// Scoreboard bench for address_hold_buffer.
// Queue-based reference model updated from the handshakes seen each cycle.
module tb_address_hold_buffer;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              flush;
  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [TAG_W-1:0]  push_tag;
  logic              push_is_write;
  logic              pop_valid;
  logic              pop_ready;
  logic [ADDR_W-1:0] pop_addr;
  logic [TAG_W-1:0]  pop_tag;
  logic              pop_is_write;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [3:0]        count;
  logic              full;
  logic              empty;

  address_hold_buffer #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_tag(push_tag),
    .push_is_write(push_is_write),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_addr(pop_addr), .pop_tag(pop_tag),
    .pop_is_write(pop_is_write),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [TAG_W-1:0]  t;
    logic              w;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_hit(input logic [ADDR_W-1:0] la);
    foreach (q[i]) if (q[i].w && q[i].a == la) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compare on the falling edge, then apply this cycle's handshakes.
  logic pu, po;
  ent_t ne;
  always @(negedge clk) begin
    if (!n_rst) begin
      q.delete();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_push_ready", push_ready, 1);
      chk("rst_pop_valid", pop_valid, 0);
      chk("rst_hit", lookup_hit, 0);
      chk("rst_pop_addr", pop_addr, 0);
      chk("rst_pop_tag", pop_tag, 0);
      chk("rst_pop_is_write", pop_is_write, 0);
    end else begin
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("push_ready", push_ready, q.size() < DEPTH);
      chk("pop_valid", pop_valid, q.size() > 0);
      chk("lookup_hit", lookup_hit, model_hit(lookup_addr));
      if (q.size() > 0) begin
        chk("pop_addr", pop_addr, q[0].a);
        chk("pop_tag", pop_tag, q[0].t);
        chk("pop_is_write", pop_is_write, q[0].w);
      end else begin
        chk("pop_addr_empty", pop_addr, 0);
        chk("pop_tag_empty", pop_tag, 0);
        chk("pop_wr_empty", pop_is_write, 0);
      end
      if (flush) begin
        q.delete();
      end else begin
        pu = push_valid && (q.size() < DEPTH);
        po = pop_ready && (q.size() > 0);
        if (po) void'(q.pop_front());
        if (pu) begin
          ne.a = push_addr;
          ne.t = push_tag;
          ne.w = push_is_write;
          q.push_back(ne);
        end
      end
    end
  end

  task automatic cyc(input logic pv, input logic [31:0] a,
                     input logic [3:0] t, input logic w,
                     input logic pr, input logic fl,
                     input logic [31:0] la);
    push_valid    = pv;
    push_addr     = a;
    push_tag      = t;
    push_is_write = w;
    pop_ready     = pr;
    flush         = fl;
    lookup_addr   = la;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0;
    flush = 0; push_valid = 0; push_addr = 0; push_tag = 0;
    push_is_write = 0; pop_ready = 0; lookup_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Single write entry and hazard lookups
    cyc(1, 32'h1000, 4'd3, 1, 0, 0, 32'h1000);
    cyc(0, 0, 0, 0, 0, 0, 32'h1000);
    cyc(0, 0, 0, 0, 0, 0, 32'h1004);
    cyc(1, 32'h2000, 4'd5, 0, 0, 0, 32'h2000);
    cyc(0, 0, 0, 0, 0, 0, 32'h2000);
    cyc(0, 0, 0, 0, 1, 0, 32'h1000);
    cyc(0, 0, 0, 0, 1, 0, 32'h1000);

    // Fill, refused 9th push, drain, pop while empty
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 32'h10 * i, 4'(i), i[0], 0, 0, 32'h30);
    cyc(1, 32'h999, 4'hf, 1, 0, 0, 32'h999);
    cyc(1, 32'h998, 4'he, 1, 1, 0, 32'h10);
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 0, 0, 0, 1, 0, 32'h50);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Concurrent push/pop at count 4 across the pointer wrap
    for (int i = 0; i < 4; i++)
      cyc(1, 32'h100 + i, 4'(i), 1, 0, 0, 32'h100);
    for (int i = 0; i < 12; i++)
      cyc(1, 32'h200 + i, 4'(i + 4), i[0], 1, 0, 32'h200 + i);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, 1, 0, 0);

    // Flush with a simultaneous push
    for (int i = 0; i < 5; i++)
      cyc(1, 32'h300 + i, 4'(i), 1, 0, 0, 32'h300);
    cyc(1, 32'h400, 4'h9, 1, 1, 1, 32'h300);
    cyc(0, 0, 0, 0, 0, 0, 32'h400);
    cyc(0, 0, 0, 0, 0, 0, 32'h300);

    // Randomized traffic on a small address pool to provoke hits
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 7)) << 4,
          4'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 40) == 0), 32'($urandom_range(0, 7)) << 4);

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 4; i++)
      cyc(1, 32'h500 + i, 4'(i), 1, 0, 0, 32'h500);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_hit", lookup_hit, 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, 32'h500);
    cyc(1, 32'h600, 4'h1, 1, 0, 0, 32'h600);
    cyc(0, 0, 0, 0, 1, 0, 32'h600);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
